// File: rtl/temp_codes_pkg.sv
// Shared PS/2 Set-2 digit scancodes, limits and state encoding for the
// temperature scancode encoder and decoder.
package temp_codes_pkg;

  // Digit make codes
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] TEMP_MAX = 8'd99;

  // State encoding
  localparam int unsigned StateWidth = 2;
  localparam logic [StateWidth-1:0] StIdleEnc = 2'd0;
  localparam logic [StateWidth-1:0] StConvEnc = 2'd1;
  localparam logic [StateWidth-1:0] StEmitEnc = 2'd2;
  localparam logic [StateWidth-1:0] StFinEnc  = 2'd3;

  typedef enum logic [StateWidth-1:0] {
    StIdle = StIdleEnc,
    StConv = StConvEnc,
    StEmit = StEmitEnc,
    StFin  = StFinEnc
  } state_e;

endpackage

// File: rtl/digit_scancode_lut.sv
// Combinational decimal digit to PS/2 Set-2 make code; non-digits map to 0.
module digit_scancode_lut
  import temp_codes_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_code
);

  // Digit lookup
  always_comb begin
    o_code = 8'h00;
    case (i_digit)
      4'd0:    o_code = SC_0;
      4'd1:    o_code = SC_1;
      4'd2:    o_code = SC_2;
      4'd3:    o_code = SC_3;
      4'd4:    o_code = SC_4;
      4'd5:    o_code = SC_5;
      4'd6:    o_code = SC_6;
      4'd7:    o_code = SC_7;
      4'd8:    o_code = SC_8;
      4'd9:    o_code = SC_9;
      default: o_code = 8'h00;
    endcase
  end

endmodule

// File: rtl/temp_scancode_encoder.sv
// Temperature (0..99) to PS/2 digit scancode byte stream, tens digit first,
// emitted over a valid/ready handshake. All outputs are registered.
module temp_scancode_encoder
  import temp_codes_pkg::*;
#(
  parameter bit SEND_BREAK            = 1'b1,
  parameter bit SUPPRESS_LEADING_ZERO = 1'b0
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Bandera,
  input  logic [7:0] TEMP,
  input  logic       code_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Slot layout: with break [T, F0, T, U, F0, U], without [T, U]
  localparam logic [2:0] FullLen = SEND_BREAK ? 3'd6 : 3'd2;

  state_e     r_state, w_state_d;
  logic [7:0] r_rem, w_rem_d;
  logic [3:0] r_tens, w_tens_d;
  logic [2:0] r_idx, w_idx_d;
  logic [2:0] r_len, w_len_d;
  logic [7:0] r_code_out, w_code_out_d;
  logic       r_code_valid, w_code_valid_d;
  logic       r_busy, w_busy_d;
  logic       r_done, w_done_d;
  logic       r_err, w_err_d;

  logic [7:0] w_tens_code;
  logic [7:0] w_units_code;
  logic [2:0] w_ofs;
  logic [2:0] w_idx_nxt;
  logic [2:0] w_slot_cur;
  logic [2:0] w_slot_nxt;

  digit_scancode_lut u_tens_lut (
    .i_digit (r_tens),
    .o_code  (w_tens_code)
  );

  // Once CONV ends, rem holds the units digit
  digit_scancode_lut u_units_lut (
    .i_digit (r_rem[3:0]),
    .o_code  (w_units_code)
  );

  function automatic logic [7:0] slot_byte(input logic [2:0] slot, input logic [7:0] t,
                                           input logic [7:0] u);
    logic [7:0] b;
    b = 8'h00;
    if (SEND_BREAK) begin
      case (slot)
        3'd0, 3'd2: b = t;
        3'd1, 3'd4: b = SC_BREAK;
        3'd3, 3'd5: b = u;
        default:    b = 8'h00;
      endcase
    end else begin
      case (slot)
        3'd0:    b = t;
        3'd1:    b = u;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Slot offset skips the tens bytes when a leading zero is suppressed
  always_comb begin
    w_ofs = 3'd0;
    if (SUPPRESS_LEADING_ZERO && (r_tens == 4'd0)) begin
      w_ofs = SEND_BREAK ? 3'd3 : 3'd1;
    end
    w_idx_nxt  = r_idx + 3'd1;
    w_slot_cur = r_idx + w_ofs;
    w_slot_nxt = w_idx_nxt + w_ofs;
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_d      = r_state;
    w_rem_d        = r_rem;
    w_tens_d       = r_tens;
    w_idx_d        = r_idx;
    w_len_d        = r_len;
    w_code_out_d   = r_code_out;
    w_code_valid_d = r_code_valid;
    w_busy_d       = r_busy;
    w_done_d       = 1'b0;
    w_err_d        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (Bandera) begin
          w_rem_d   = TEMP;
          w_tens_d  = 4'd0;
          w_busy_d  = 1'b1;
          w_state_d = (TEMP > TEMP_MAX) ? StFin : StConv;
        end
      end
      StConv: begin
        if (r_rem >= 8'd10) begin
          w_rem_d  = r_rem - 8'd10;
          w_tens_d = r_tens + 4'd1;
        end else begin
          w_idx_d   = 3'd0;
          w_len_d   = FullLen - w_ofs;
          w_state_d = StEmit;
        end
      end
      StEmit: begin
        if (!r_code_valid) begin
          w_code_out_d   = slot_byte(w_slot_cur, w_tens_code, w_units_code);
          w_code_valid_d = 1'b1;
        end else if (code_ready) begin
          if (w_idx_nxt == r_len) begin
            w_code_valid_d = 1'b0;
            w_code_out_d   = 8'h00;
            w_state_d      = StFin;
          end else begin
            w_idx_d      = w_idx_nxt;
            w_code_out_d = slot_byte(w_slot_nxt, w_tens_code, w_units_code);
          end
        end
      end
      StFin: begin
        w_done_d  = 1'b1;
        // rem still holds the captured value only on the out-of-range path
        w_err_d   = (r_rem > TEMP_MAX);
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_rem        <= 8'h00;
      r_tens       <= 4'd0;
      r_idx        <= 3'd0;
      r_len        <= 3'd0;
      r_code_out   <= 8'h00;
      r_code_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_rem        <= w_rem_d;
      r_tens       <= w_tens_d;
      r_idx        <= w_idx_d;
      r_len        <= w_len_d;
      r_code_out   <= w_code_out_d;
      r_code_valid <= w_code_valid_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
    end
  end

  assign code_out   = r_code_out;
  assign code_valid = r_code_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_temp_scancode_encoder.sv
// Bench for temp_scancode_encoder: three parameterisations share stimulus;
// collected byte streams are compared with a decimal-arithmetic reference.
module tb_temp_scancode_encoder;

  logic       CLK;
  logic       reset;
  logic       Bandera;
  logic [7:0] TEMP;
  logic       code_ready;

  // Instance 0: break on; 1: break off, suppress on; 2: break off, suppress off
  logic [7:0] co [3];
  logic       cv [3];
  logic       bz [3];
  logic       dn [3];
  logic       er [3];

  temp_scancode_encoder #(.SEND_BREAK(1'b1), .SUPPRESS_LEADING_ZERO(1'b0)) dut0 (
    .CLK(CLK), .reset(reset), .Bandera(Bandera), .TEMP(TEMP), .code_ready(code_ready),
    .code_out(co[0]), .code_valid(cv[0]), .busy(bz[0]), .done(dn[0]), .err(er[0])
  );
  temp_scancode_encoder #(.SEND_BREAK(1'b0), .SUPPRESS_LEADING_ZERO(1'b1)) dut1 (
    .CLK(CLK), .reset(reset), .Bandera(Bandera), .TEMP(TEMP), .code_ready(code_ready),
    .code_out(co[1]), .code_valid(cv[1]), .busy(bz[1]), .done(dn[1]), .err(er[1])
  );
  temp_scancode_encoder #(.SEND_BREAK(1'b0), .SUPPRESS_LEADING_ZERO(1'b0)) dut2 (
    .CLK(CLK), .reset(reset), .Bandera(Bandera), .TEMP(TEMP), .code_ready(code_ready),
    .code_out(co[2]), .code_valid(cv[2]), .busy(bz[2]), .done(dn[2]), .err(er[2])
  );

  logic [7:0] lut_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;
  int ready_mode = 0;
  int stall_left = 0;

  logic [7:0] got [3][8];
  int got_n [3];
  int valid_cyc [3];
  int first_valid [3];
  int done_n [3];
  int done_cyc [3];
  int err_n [3];
  int busy_n [3];
  logic       prev_stall [3];
  logic [7:0] prev_co [3];

  logic [7:0] exp_q [$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, then assemble the byte list
  function automatic void build_exp(input int t, input bit brk, input bit sup);
    int tn;
    int un;
    exp_q.delete();
    if (t > 99) return;
    tn = t / 10;
    un = t % 10;
    if (!(sup && tn == 0)) begin
      exp_q.push_back(lut_tab[tn]);
      if (brk) begin
        exp_q.push_back(8'hF0);
        exp_q.push_back(lut_tab[tn]);
      end
    end
    exp_q.push_back(lut_tab[un]);
    if (brk) begin
      exp_q.push_back(8'hF0);
      exp_q.push_back(lut_tab[un]);
    end
  endfunction

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      got_n[i] = 0;
      valid_cyc[i] = 0;
      first_valid[i] = -1;
      done_n[i] = 0;
      done_cyc[i] = -1;
      err_n[i] = 0;
      busy_n[i] = 0;
    end
  endtask

  // Monitor: sample away from the active edge, record transfers and pulses
  initial begin
    for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (prev_stall[i]) begin
            chk($sformatf("hold_valid[%0d]", i), {31'd0, cv[i]}, 32'd1);
            chk($sformatf("hold_byte[%0d]", i), {24'd0, co[i]}, {24'd0, prev_co[i]});
          end
          if (cv[i] && code_ready) begin
            if (got_n[i] < 8) got[i][got_n[i]] = co[i];
            got_n[i]++;
          end
          if (cv[i]) begin
            valid_cyc[i]++;
            if (first_valid[i] < 0) first_valid[i] = cyc;
          end
          if (dn[i]) begin
            done_n[i]++;
            done_cyc[i] = cyc;
          end
          if (er[i]) err_n[i]++;
          if (bz[i]) busy_n[i]++;
          prev_stall[i] = cv[i] && !code_ready;
          prev_co[i]    = co[i];
        end
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = one 5-cycle stall on byte 2
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0: code_ready = 1'b1;
        1: code_ready = 1'($urandom_range(0, 1));
        default: begin
          if (got_n[0] == 1 && stall_left > 0) begin
            code_ready = 1'b0;
            stall_left--;
          end else begin
            code_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic start(input int t);
    @(posedge CLK);
    #1;
    Bandera   = 1'b1;
    TEMP      = t[7:0];
    start_cyc = cyc + 1;
    @(posedge CLK);
    #1;
    Bandera = 1'b0;
  endtask

  task automatic check_run(input int t, input int rmode, input string tag);
    int tn;
    int n;
    int lat;
    for (int i = 0; i < 3; i++) begin
      build_exp(t, (i == 0), (i == 1));
      chk($sformatf("%s t=%0d nbytes[%0d]", tag, t, i), got_n[i], exp_q.size());
      for (int j = 0; j < exp_q.size(); j++) begin
        if (j < got_n[i] && j < 8)
          chk($sformatf("%s t=%0d byte%0d[%0d]", tag, t, j, i), {24'd0, got[i][j]},
              {24'd0, exp_q[j]});
      end
      chk($sformatf("%s t=%0d done_cnt[%0d]", tag, t, i), done_n[i], 1);
      chk($sformatf("%s t=%0d err_cnt[%0d]", tag, t, i), err_n[i], (t > 99) ? 1 : 0);
    end
    if (rmode == 0) begin
      build_exp(t, 1'b1, 1'b0);
      n   = exp_q.size();
      tn  = t / 10;
      lat = (t > 99) ? 1 : tn + 3 + n;
      chk($sformatf("%s t=%0d valid_cycles", tag, t), valid_cyc[0], n);
      chk($sformatf("%s t=%0d done_latency", tag, t), done_cyc[0] - start_cyc, lat);
      chk($sformatf("%s t=%0d busy_cycles", tag, t), busy_n[0], lat);
      if (t <= 99)
        chk($sformatf("%s t=%0d first_byte_latency", tag, t), first_valid[0] - start_cyc,
            tn + 2);
    end
  endtask

  task automatic run(input int t, input int rmode, input bit mid, input string tag);
    bit pulsed;
    pulsed = 1'b0;
    clear_mon();
    ready_mode = rmode;
    start(t);
    for (int k = 0; k < 400; k++) begin
      if (done_n[0] > 0 && done_n[1] > 0 && done_n[2] > 0) break;
      @(posedge CLK);
      #1;
      if (mid && !pulsed && first_valid[0] >= 0) begin
        Bandera = 1'b1;
        TEMP    = 8'd11;
        @(posedge CLK);
        #1;
        Bandera = 1'b0;
        pulsed  = 1'b1;
      end
    end
    repeat (25) @(posedge CLK);
    #1;
    check_run(t, rmode, tag);
  endtask

  initial begin
    int t;
    int m;
    reset      = 1'b0;
    Bandera    = 1'b0;
    TEMP       = 8'd0;
    code_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset code_out[%0d]", i), {24'd0, co[i]}, 32'd0);
      chk($sformatf("reset flags[%0d]", i), {28'd0, cv[i], bz[i], dn[i], er[i]}, 32'd0);
    end
    @(negedge CLK);
    reset = 1'b1;

    run(37, 0, 1'b0, "t37");
    run(0, 0, 1'b0, "t0");
    run(99, 0, 1'b0, "t99");
    run(100, 0, 1'b0, "t100");
    stall_left = 5;
    run(52, 2, 1'b0, "stall52");
    run(52, 0, 1'b1, "midstart52");

    // Asynchronous reset during the third byte
    clear_mon();
    ready_mode = 0;
    start(24);
    for (int k = 0; k < 100; k++) begin
      if (got_n[0] >= 2) break;
      @(posedge CLK);
      #1;
    end
    chk("rst24 reached_byte3", (got_n[0] >= 2) ? 32'd1 : 32'd0, 32'd1);
    @(negedge CLK);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst24 code_out[%0d]", i), {24'd0, co[i]}, 32'd0);
      chk($sformatf("rst24 flags[%0d]", i), {28'd0, cv[i], bz[i], dn[i], er[i]}, 32'd0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    clear_mon();
    repeat (10) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst24 quiet[%0d]", i), valid_cyc[i] + busy_n[i] + done_n[i], 0);
    run(24, 0, 1'b0, "after_rst24");

    for (int r = 0; r < 30; r++) begin
      t = int'($urandom_range(0, 120));
      m = int'($urandom_range(0, 1));
      run(t, m, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
